popcnt_argmax: RTL and testbench

- Streaming consumer on the downstream side of the vector-popcount pipeline. It accepts per-class popcount scores over the same in_valid/this_ready/out_valid/next_ready handshake and reduces each frame of CLASS_NUM scores to a winning class index, its score and a margin over the runner-up.
- It is the classification back end for the HDC/BNN similarity datapath on the Zynq PL.

---
 rtl/popcnt_pkg.sv | 17 +
 rtl/popcnt_argmax_if.sv | 29 ++
 rtl/popcnt_cmp_update.sv | 42 ++++
 rtl/popcnt_argmax.sv | 132 +++++++++++++
 tb/tb_popcnt_argmax.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/popcnt_pkg.sv
// Shared definitions for the popcount pipeline and its argmax back end:
// the controller state encoding, the default score width and an index-width helper.
package popcnt_pkg;

  // clog2(1100+1): largest popcount produced by the similarity datapath
  localparam int POPCNT_WIDTH_DEF = 11;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/popcnt_argmax_if.sv
// Score-in / result-out handshake bundle between the popcount pipeline,
// the argmax back end and its downstream consumer.
interface popcnt_argmax_if #(
  parameter int POPCNT_WIDTH = 11,
  parameter int IDX_WIDTH    = 4
) ();

  logic [POPCNT_WIDTH-1:0] popcount;
  logic                    in_last;
  logic                    in_valid;
  logic                    this_ready;
  logic                    out_valid;
  logic                    next_ready;
  logic [IDX_WIDTH-1:0]    class_idx;
  logic [POPCNT_WIDTH-1:0] best_score;
  logic [POPCNT_WIDTH-1:0] margin;
  logic                    frame_err;

  modport master (
    output popcount, in_last, in_valid, next_ready,
    input  this_ready, out_valid, class_idx, best_score, margin, frame_err
  );

  modport slave (
    input  popcount, in_last, in_valid, next_ready,
    output this_ready, out_valid, class_idx, best_score, margin, frame_err
  );

endinterface

// File: rtl/popcnt_cmp_update.sv
// Combinational best/runner-up tracker: folds one score at position k into the
// running (best, second, best_idx) triple. Position 0 restarts the frame.
module popcnt_cmp_update #(
  parameter int POPCNT_WIDTH = 11,
  parameter int IDX_WIDTH    = 4,
  parameter bit SELECT_MIN   = 1'b0
) (
  input  logic [POPCNT_WIDTH-1:0] best,
  input  logic [POPCNT_WIDTH-1:0] second,
  input  logic [IDX_WIDTH-1:0]    best_idx,
  input  logic [POPCNT_WIDTH-1:0] popcount,
  input  logic [IDX_WIDTH-1:0]    k,
  output logic [POPCNT_WIDTH-1:0] best_n,
  output logic [POPCNT_WIDTH-1:0] second_n,
  output logic [IDX_WIDTH-1:0]    best_idx_n
);

  logic beats_best;
  logic beats_second;

  // strict compares: a tie never displaces the incumbent, so the lowest index wins
  assign beats_best   = SELECT_MIN ? (popcount < best)   : (popcount > best);
  assign beats_second = SELECT_MIN ? (popcount < second) : (popcount > second);

  always_comb begin
    best_n     = best;
    second_n   = second;
    best_idx_n = best_idx;
    if (k == '0) begin
      best_n     = popcount;
      second_n   = SELECT_MIN ? '1 : '0;
      best_idx_n = '0;
    end else if (beats_best) begin
      second_n   = best;
      best_n     = popcount;
      best_idx_n = k;
    end else if (beats_second) begin
      second_n   = popcount;
    end
  end

endmodule

// File: rtl/popcnt_argmax.sv
// Reduces each frame of CLASS_NUM popcount scores to winning index, score and
// margin over the runner-up, with a frame-alignment error flag.
//   state | meaning
//   ACCUM | collecting scores of the current frame
//   HOLD  | result registered, waiting for the downstream to take it
module popcnt_argmax
  import popcnt_pkg::*;
#(
  parameter int CLASS_NUM    = 10,
  parameter int POPCNT_WIDTH = POPCNT_WIDTH_DEF,
  parameter bit SELECT_MIN   = 1'b0,
  parameter int IDX_WIDTH    = idx_width(CLASS_NUM)
) (
  input  logic            clk,
  input  logic            rst,
  popcnt_argmax_if.slave  bus
);

  localparam logic [IDX_WIDTH-1:0] LAST_K = IDX_WIDTH'(CLASS_NUM - 1);

  state_e                  state_q, state_d;
  logic [IDX_WIDTH-1:0]    cnt_q, cnt_d;
  logic [POPCNT_WIDTH-1:0] best_q, best_d;
  logic [POPCNT_WIDTH-1:0] second_q, second_d;
  logic [IDX_WIDTH-1:0]    best_idx_q, best_idx_d;
  logic                    err_acc_q, err_acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [IDX_WIDTH-1:0]    class_idx_q, class_idx_d;
  logic [POPCNT_WIDTH-1:0] best_score_q, best_score_d;
  logic [POPCNT_WIDTH-1:0] margin_q, margin_d;
  logic                    frame_err_q, frame_err_d;

  logic [POPCNT_WIDTH-1:0] upd_best, upd_second;
  logic [IDX_WIDTH-1:0]    upd_idx;
  logic                    this_ready, accept, emit;

  assign this_ready = (state_q == ACCUM) || ((state_q == HOLD) && bus.next_ready);
  assign accept     = bus.in_valid && this_ready;
  assign emit       = out_valid_q && bus.next_ready;

  // one instance serves both the running fold and the final fold of a frame
  popcnt_cmp_update #(
    .POPCNT_WIDTH (POPCNT_WIDTH),
    .IDX_WIDTH    (IDX_WIDTH),
    .SELECT_MIN   (SELECT_MIN)
  ) u_cmp (
    .best       (best_q),
    .second     (second_q),
    .best_idx   (best_idx_q),
    .popcount   (bus.popcount),
    .k          (cnt_q),
    .best_n     (upd_best),
    .second_n   (upd_second),
    .best_idx_n (upd_idx)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    best_d       = best_q;
    second_d     = second_q;
    best_idx_d   = best_idx_q;
    err_acc_d    = err_acc_q;
    out_valid_d  = out_valid_q;
    class_idx_d  = class_idx_q;
    best_score_d = best_score_q;
    margin_d     = margin_q;
    frame_err_d  = frame_err_q;

    if (state_q == HOLD && emit) begin
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end

    if (accept) begin
      best_d     = upd_best;
      second_d   = upd_second;
      best_idx_d = upd_idx;
      if (cnt_q == '0) err_acc_d = bus.in_last;
      else if (cnt_q != LAST_K) err_acc_d = err_acc_q | bus.in_last;

      if (cnt_q == LAST_K) begin
        class_idx_d  = upd_idx;
        best_score_d = upd_best;
        margin_d     = (upd_best >= upd_second) ? (upd_best - upd_second)
                                                : (upd_second - upd_best);
        frame_err_d  = err_acc_q | ~bus.in_last;
        out_valid_d  = 1'b1;
        state_d      = HOLD;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      cnt_q        <= '0;
      best_q       <= '0;
      second_q     <= '0;
      best_idx_q   <= '0;
      err_acc_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      class_idx_q  <= '0;
      best_score_q <= '0;
      margin_q     <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      best_q       <= best_d;
      second_q     <= second_d;
      best_idx_q   <= best_idx_d;
      err_acc_q    <= err_acc_d;
      out_valid_q  <= out_valid_d;
      class_idx_q  <= class_idx_d;
      best_score_q <= best_score_d;
      margin_q     <= margin_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.this_ready = this_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.class_idx  = class_idx_q;
  assign bus.best_score = best_score_q;
  assign bus.margin     = margin_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_popcnt_argmax.sv
// Directed bench for popcnt_argmax: a max-mode and a min-mode instance with
// CLASS_NUM=4, hand-computed expected results per frame.
module tb_popcnt_argmax;
  import popcnt_pkg::*;

  localparam int CN = 4;
  localparam int PW = POPCNT_WIDTH_DEF;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] popcount = '0;
  logic          in_last = 1'b0;
  logic          vld_max = 1'b0;
  logic          vld_min = 1'b0;
  logic          next_ready = 1'b1;
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            t_a, t_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  popcnt_argmax_if #(.POPCNT_WIDTH(PW), .IDX_WIDTH(IW)) if_max ();
  popcnt_argmax_if #(.POPCNT_WIDTH(PW), .IDX_WIDTH(IW)) if_min ();

  assign if_max.popcount   = popcount;
  assign if_max.in_last    = in_last;
  assign if_max.in_valid   = vld_max;
  assign if_max.next_ready = next_ready;
  assign if_min.popcount   = popcount;
  assign if_min.in_last    = in_last;
  assign if_min.in_valid   = vld_min;
  assign if_min.next_ready = next_ready;

  popcnt_argmax #(.CLASS_NUM(CN), .POPCNT_WIDTH(PW), .SELECT_MIN(1'b0), .IDX_WIDTH(IW))
    dut_max (.clk(clk), .rst(rst), .bus(if_max));
  popcnt_argmax #(.CLASS_NUM(CN), .POPCNT_WIDTH(PW), .SELECT_MIN(1'b1), .IDX_WIDTH(IW))
    dut_min (.clk(clk), .rst(rst), .bus(if_min));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? if_min.this_ready : if_max.this_ready;
  endfunction

  // called at a negedge; returns at the negedge after the score was accepted
  task automatic put(input bit sel, input int score, input logic last);
    int   t;
    logic r;
    popcount = PW'(score);
    in_last  = last;
    if (sel) vld_min = 1'b1;
    else     vld_max = 1'b1;
    t = 0;
    forever begin
      #1;
      r = rdy(sel);
      @(posedge clk);
      if (r) break;
      t++;
      if (t > 20) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    vld_max = 1'b0;
    vld_min = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic frame(input bit sel, input int a, input int b, input int c, input int d,
                       input logic [3:0] lm);
    put(sel, a, lm[0]);
    put(sel, b, lm[1]);
    put(sel, c, lm[2]);
    put(sel, d, lm[3]);
    idle();
  endtask

  task automatic res(input string tag, input bit sel, input int ov, input int idx,
                     input int best, input int mg, input int fe);
    if (sel) begin
      chk({tag, ".out_valid"},  32'(if_min.out_valid),  32'(ov));
      chk({tag, ".class_idx"},  32'(if_min.class_idx),  32'(idx));
      chk({tag, ".best_score"}, 32'(if_min.best_score), 32'(best));
      chk({tag, ".margin"},     32'(if_min.margin),     32'(mg));
      chk({tag, ".frame_err"},  32'(if_min.frame_err),  32'(fe));
    end else begin
      chk({tag, ".out_valid"},  32'(if_max.out_valid),  32'(ov));
      chk({tag, ".class_idx"},  32'(if_max.class_idx),  32'(idx));
      chk({tag, ".best_score"}, 32'(if_max.best_score), 32'(best));
      chk({tag, ".margin"},     32'(if_max.margin),     32'(mg));
      chk({tag, ".frame_err"},  32'(if_max.frame_err),  32'(fe));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    res("reset_max", 1'b0, 0, 0, 0, 0, 0);
    res("reset_min", 1'b1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.ready_max", 32'(if_max.this_ready), 32'd1);
    chk("reset.ready_min", 32'(if_min.this_ready), 32'd1);

    // max mode basic and ties
    frame(1'b0, 5, 9, 3, 7, 4'b1000);
    res("basic", 1'b0, 1, 1, 9, 2, 0);
    @(negedge clk);
    chk("basic.ov_drop", 32'(if_max.out_valid), 32'd0);
    frame(1'b0, 8, 8, 2, 8, 4'b1000);
    res("ties", 1'b0, 1, 0, 8, 0, 0);
    @(negedge clk);

    // min mode
    frame(1'b1, 12, 4, 4, 30, 4'b1000);
    res("min1", 1'b1, 1, 1, 4, 0, 0);
    frame(1'b1, 6, 1, 9, 2, 4'b1000);
    res("min2", 1'b1, 1, 1, 1, 1, 0);
    @(negedge clk);

    // backpressure: result held, offered score must wait
    next_ready = 1'b0;
    frame(1'b0, 5, 9, 3, 7, 4'b1000);
    res("bp.held", 1'b0, 1, 1, 9, 2, 0);
    popcount = PW'(10);
    in_last  = 1'b0;
    vld_max  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp.this_ready", 32'(if_max.this_ready), 32'd0);
      @(negedge clk);
      res("bp.stable", 1'b0, 1, 1, 9, 2, 0);
    end
    next_ready = 1'b1;
    put(1'b0, 10, 1'b0);
    chk("bp.emitted", 32'(if_max.out_valid), 32'd0);
    put(1'b0, 2, 1'b0);
    put(1'b0, 3, 1'b0);
    put(1'b0, 4, 1'b1);
    idle();
    res("bp.next", 1'b0, 1, 0, 10, 6, 0);
    @(negedge clk);

    // back-to-back frames, in_valid held high
    put(1'b0, 1, 1'b0);
    put(1'b0, 2, 1'b0);
    put(1'b0, 3, 1'b0);
    put(1'b0, 4, 1'b1);
    t_a = cyc;
    res("b2b1", 1'b0, 1, 3, 4, 1, 0);
    put(1'b0, 7, 1'b0);
    chk("b2b.pulse", 32'(if_max.out_valid), 32'd0);
    put(1'b0, 6, 1'b0);
    put(1'b0, 5, 1'b0);
    put(1'b0, 4, 1'b1);
    t_b = cyc;
    idle();
    res("b2b2", 1'b0, 1, 0, 7, 1, 0);
    chk("b2b.gap", 32'(t_b - t_a), 32'd4);
    @(negedge clk);

    // frame alignment errors
    frame(1'b0, 1, 2, 3, 4, 4'b1010);
    res("ferr.early", 1'b0, 1, 3, 4, 1, 1);
    frame(1'b0, 4, 3, 2, 1, 4'b0000);
    res("ferr.missing", 1'b0, 1, 0, 4, 1, 1);
    frame(1'b0, 2, 6, 6, 1, 4'b1000);
    res("ferr.clean", 1'b0, 1, 1, 6, 0, 0);
    @(negedge clk);

    // reset while a result is held
    next_ready = 1'b0;
    frame(1'b0, 9, 1, 1, 1, 4'b1000);
    res("rst_hold.pre", 1'b0, 1, 0, 9, 8, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    next_ready = 1'b1;
    res("rst_hold.post", 1'b0, 0, 0, 0, 0, 0);

    // reset mid-frame, then a fresh frame
    put(1'b0, 50, 1'b0);
    put(1'b0, 60, 1'b0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    res("rst_mid.post", 1'b0, 0, 0, 0, 0, 0);
    frame(1'b0, 1, 2, 3, 4, 4'b1000);
    res("rst_mid.fresh", 1'b0, 1, 3, 4, 1, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
